// File: rtl/morse_key_timer_if.sv
// Signal bundle between the Morse key front end, the timing controller and the letter lookup.
// The dbg_* members expose controller state and the duration counter for observation.
interface morse_key_timer_if #(
    parameter int CNT_W = 8
);
    logic             key_i;
    logic             tick_i;
    logic             tick_clr_o;
    logic             sym_valid_o;
    logic             sym_dash_o;
    logic             letter_valid_o;
    logic [4:0]       letter_code_o;
    logic [2:0]       letter_len_o;
    logic             letter_err_o;
    logic             word_end_o;
    logic             busy_o;
    logic [1:0]       dbg_state_o;
    logic [CNT_W-1:0] dbg_dur_o;

    // Every *_valid / word_end output is a single-cycle pulse with no ready back-pressure:
    // the consumer must take it in the cycle it is high; qualified data is stable during that cycle.
    modport master (
        output key_i, tick_i,
        input  tick_clr_o, sym_valid_o, sym_dash_o, letter_valid_o, letter_code_o,
        input  letter_len_o, letter_err_o, word_end_o, busy_o, dbg_state_o, dbg_dur_o
    );

    modport slave (
        input  key_i, tick_i,
        output tick_clr_o, sym_valid_o, sym_dash_o, letter_valid_o, letter_code_o,
        output letter_len_o, letter_err_o, word_end_o, busy_o, dbg_state_o, dbg_dur_o
    );
endinterface

// File: rtl/morse_key_timer.sv
// Times key-down/key-up intervals in prescaler ticks, classifies dots/dashes,
// assembles up to five symbols per letter and flags letter and word gaps.
module morse_key_timer #(
    parameter int CNT_W     = 8,
    parameter int MIN_TH    = 2,
    parameter int DASH_TH   = 8,
    parameter int LETTER_TH = 8,
    parameter int WORD_TH   = 20
) (
    input  logic             clk,
    input  logic             rst,
    morse_key_timer_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MARK  = 2'd1,
        S_SPACE = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] DUR_MAX = '1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] dur_q, dur_d;
    logic [2:0]       len_q, len_d;
    logic [4:0]       code_q, code_d;
    logic             err_q, err_d;
    logic             key_d_q;

    logic             sym_valid_q, sym_valid_d;
    logic             sym_dash_q, sym_dash_d;
    logic             letter_valid_q, letter_valid_d;
    logic [4:0]       letter_code_q, letter_code_d;
    logic [2:0]       letter_len_q, letter_len_d;
    logic             letter_err_q, letter_err_d;
    logic             word_end_q, word_end_d;

    logic             rise, fall;
    logic             tick_clr_c;
    logic             dash_c;
    logic [CNT_W-1:0] dur_inc;

    assign rise    = bus.key_i & ~key_d_q;
    assign fall    = ~bus.key_i & key_d_q;
    assign dur_inc = (dur_q == DUR_MAX) ? dur_q : dur_q + CNT_W'(1);
    assign dash_c  = int'(dur_q) >= DASH_TH;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            dur_q          <= '0;
            len_q          <= '0;
            code_q         <= '0;
            err_q          <= 1'b0;
            key_d_q        <= 1'b0;
            sym_valid_q    <= 1'b0;
            sym_dash_q     <= 1'b0;
            letter_valid_q <= 1'b0;
            letter_code_q  <= '0;
            letter_len_q   <= '0;
            letter_err_q   <= 1'b0;
            word_end_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            dur_q          <= dur_d;
            len_q          <= len_d;
            code_q         <= code_d;
            err_q          <= err_d;
            key_d_q        <= bus.key_i;
            sym_valid_q    <= sym_valid_d;
            sym_dash_q     <= sym_dash_d;
            letter_valid_q <= letter_valid_d;
            letter_code_q  <= letter_code_d;
            letter_len_q   <= letter_len_d;
            letter_err_q   <= letter_err_d;
            word_end_q     <= word_end_d;
        end
    end

    // Edges always take priority over a coincident tick so every interval starts tick-aligned.
    always_comb begin
        state_d        = state_q;
        dur_d          = dur_q;
        len_d          = len_q;
        code_d         = code_q;
        err_d          = err_q;
        tick_clr_c     = 1'b0;
        sym_valid_d    = 1'b0;
        sym_dash_d     = sym_dash_q;
        letter_valid_d = 1'b0;
        letter_code_d  = letter_code_q;
        letter_len_d   = letter_len_q;
        letter_err_d   = letter_err_q;
        word_end_d     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (rise) begin
                    state_d    = S_MARK;
                    dur_d      = '0;
                    tick_clr_c = 1'b1;
                end
            end

            S_MARK: begin
                if (fall) begin
                    tick_clr_c = 1'b1;
                    dur_d      = '0;
                    if (int'(dur_q) < MIN_TH) begin
                        state_d = (len_q != 3'd0) ? S_SPACE : S_IDLE;
                    end else begin
                        state_d     = S_SPACE;
                        sym_valid_d = 1'b1;
                        sym_dash_d  = dash_c;
                        // A sixth symbol is reported but cannot be stored; the letter is marked bad.
                        if (len_q < 3'd5) begin
                            code_d = {code_q[3:0], dash_c};
                            len_d  = len_q + 3'd1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end else if (bus.tick_i) begin
                    dur_d = dur_inc;
                end
            end

            S_SPACE: begin
                if (rise) begin
                    state_d    = S_MARK;
                    dur_d      = '0;
                    tick_clr_c = 1'b1;
                end else if (bus.tick_i) begin
                    dur_d = dur_inc;
                    if (int'(dur_inc) == LETTER_TH && len_q != 3'd0) begin
                        letter_valid_d = 1'b1;
                        letter_code_d  = code_q;
                        letter_len_d   = len_q;
                        letter_err_d   = err_q;
                        code_d         = '0;
                        len_d          = '0;
                        err_d          = 1'b0;
                    end
                    if (int'(dur_inc) == WORD_TH) begin
                        word_end_d = 1'b1;
                        state_d    = S_IDLE;
                        dur_d      = '0;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                dur_d   = '0;
            end
        endcase
    end

    // tick_clr is combinational; gating with reset keeps every output low while reset is held.
    assign bus.tick_clr_o     = rst & tick_clr_c;
    assign bus.sym_valid_o    = sym_valid_q;
    assign bus.sym_dash_o     = sym_dash_q;
    assign bus.letter_valid_o = letter_valid_q;
    assign bus.letter_code_o  = letter_code_q;
    assign bus.letter_len_o   = letter_len_q;
    assign bus.letter_err_o   = letter_err_q;
    assign bus.word_end_o     = word_end_q;
    assign bus.busy_o         = (state_q != S_IDLE);
    assign bus.dbg_state_o    = state_q;
    assign bus.dbg_dur_o      = dur_q;

    a_sym_letter_exclusive : assert property (
        @(posedge clk) disable iff (!rst) !(sym_valid_q && letter_valid_q)
    );

endmodule
